reg_file_sb: RTL

//  Parametrised multi-read-port register file with an integrated pending-write scoreboard.

---
 rtl/reg_file_sb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with per-register pending-write counters for hazard tracking.
// Latency: reads are combinational (0 cycles); writes and counter updates land on the next clk edge.
// Backpressure: iss_ready drops only while the issue target's counter is full, with no same-cycle write to it and no flush.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   rd_addr / rd_data     NUM_RD packed read ports, port k at [k*W +: W]
//   rd_busy               per read port: addressed register still has a write in flight
//   wr_en/addr/data       writeback port
//   iss_valid/addr/ready  issue handshake; an accepted issue marks iss_addr pending
//   flush                 clear every pending counter
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int PEND_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     flush
);

    localparam logic [ADDR_W:0]   NREGS   = (ADDR_W+1)'(NUM_REGS);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [PEND_W-1:0] cnt_q  [NUM_REGS];
    logic [PEND_W-1:0] cnt_d  [NUM_REGS];

    logic              wr_ok;
    logic              iss_tgt_ok;
    logic              iss_acc;
    logic [PEND_W-1:0] iss_cnt;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // A write or issue only counts when it targets a real, writable register.
    assign wr_ok      = wr_en && in_range(wr_addr) && !is_zero_reg(wr_addr);
    assign iss_tgt_ok = in_range(iss_addr) && !is_zero_reg(iss_addr);

    // Issue handshake. A same-cycle writeback to the full register frees a slot,
    // and a flush empties every counter, so either keeps the issue port open.
    always_comb begin
        iss_cnt = '0;
        if (in_range(iss_addr)) begin
            iss_cnt = cnt_q[iss_addr];
        end
        iss_ready = !((iss_cnt == CNT_MAX) && !(wr_ok && (wr_addr == iss_addr)) && !flush);
        iss_acc   = iss_valid && iss_ready && iss_tgt_ok;
    end

    // Next-state for storage and pending counters.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            logic inc;
            logic dec;
            inc       = iss_acc && (iss_addr == ADDR_W'(r));
            dec       = wr_ok && (wr_addr == ADDR_W'(r));
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_q[r];
            if (dec) begin
                regs_d[r] = wr_data;
            end
            // Issue and writeback to the same register cancel out; decrement saturates at 0.
            if (flush) begin
                cnt_d[r] = '0;
            end else if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && !inc && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    // Read ports. With bypass, a register whose last outstanding write is landing
    // this cycle is reported not busy because the forwarded value is final.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [PEND_W-1:0] c;
        logic              fwd;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a   = rd_addr[k*ADDR_W +: ADDR_W];
            d   = '0;
            c   = '0;
            fwd = 1'b0;
            if (in_range(a)) begin
                d   = regs_q[a];
                c   = cnt_q[a];
                fwd = (BYPASS != 0) && wr_ok && (wr_addr == a);
            end
            if (fwd) begin
                d = wr_data;
            end
            rd_data[k*DATA_W +: DATA_W] = d;
            rd_busy[k] = (c != '0) && !(fwd && (c == CNT_ONE));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
        end
    end

endmodule
